// File: rtl/hamming_secded_pipe_if.sv
// Handshake and data bundle for the pipelined SECDED codec.
// master drives words in and takes results out; slave is the codec.
interface hamming_secded_pipe_if #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 16
);
    function automatic int calcP(input int dw);
        int p;
        p = 0;
        for (int i = 7; i >= 1; i--) begin
            if ((1 << i) >= dw + i + 1) begin
                p = i;
            end else begin
                p = p;
            end
        end
        return p;
    endfunction

    localparam int P  = calcP(DATA_W);
    localparam int CW = DATA_W + P + 1;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CW-1:0]     in_code;
    logic              src_sel;
    logic [CW-1:0]     err_mask;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CW-1:0]     out_code;
    logic [P-1:0]      out_syndrome;
    logic              out_single;
    logic              out_double;
    logic              cnt_clr;
    logic [CNT_W-1:0]  cnt_single;
    logic [CNT_W-1:0]  cnt_double;

    modport master (
        output in_valid, in_data, in_code, src_sel, err_mask, out_ready, cnt_clr,
        input  in_ready, out_valid, out_data, out_code, out_syndrome,
               out_single, out_double, cnt_single, cnt_double
    );

    modport slave (
        input  in_valid, in_data, in_code, src_sel, err_mask, out_ready, cnt_clr,
        output in_ready, out_valid, out_data, out_code, out_syndrome,
               out_single, out_double, cnt_single, cnt_double
    );
endinterface

// File: rtl/hamming_secded_pipe.sv
// Two-stage Hamming SECDED codec: stage 1 encodes or takes an external codeword and
// injects errors, stage 2 decodes, corrects single errors and flags uncorrectable words.
module hamming_secded_pipe #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 16
) (
    input logic                  clk,
    input logic                  rst,
    hamming_secded_pipe_if.slave bus
);
    function automatic int calcP(input int dw);
        int p;
        p = 0;
        for (int i = 7; i >= 1; i--) begin
            if ((1 << i) >= dw + i + 1) begin
                p = i;
            end else begin
                p = p;
            end
        end
        return p;
    endfunction

    localparam int P  = calcP(DATA_W);
    localparam int CW = DATA_W + P + 1;
    localparam logic [CW-1:0] oneCw = {{(CW-1){1'b0}}, 1'b1};

    function automatic logic isPow2(input int pos);
        return (pos & (pos - 1)) == 0;
    endfunction

    // Data fills non-power-of-two positions; parity bits cover positions sharing their index bit.
    function automatic logic [CW-1:0] encode(input logic [DATA_W-1:0] d);
        logic [CW-1:0] c;
        logic          par;
        int            k;
        c = '0;
        k = 0;
        for (int pos = 1; pos < CW; pos++) begin
            if (!isPow2(pos)) begin
                c[pos] = d[k];
                k++;
            end
        end
        for (int b = 0; b < P; b++) begin
            par = 1'b0;
            for (int pos = 1; pos < CW; pos++) begin
                par = par ^ (c[pos] & pos[b]);
            end
            c[1 << b] = par;
        end
        c[0] = ^c[CW-1:1];
        return c;
    endfunction

    function automatic logic [P-1:0] syndrome(input logic [CW-1:0] c);
        logic [P-1:0] s;
        s = '0;
        for (int pos = 1; pos < CW; pos++) begin
            s = s ^ (P'(pos) & {P{c[pos]}});
        end
        return s;
    endfunction

    function automatic logic [DATA_W-1:0] extract(input logic [CW-1:0] c);
        logic [DATA_W-1:0] d;
        int                k;
        d = '0;
        k = 0;
        for (int pos = 1; pos < CW; pos++) begin
            if (!isPow2(pos)) begin
                d[k] = c[pos];
                k++;
            end
        end
        return d;
    endfunction

    logic              s1Valid_r;
    logic [CW-1:0]     s1Code_r;
    logic [CW-1:0]     stage1Word_s;
    logic              inFire_s;
    logic              s2Load_s;
    logic              outFire_s;
    logic [P-1:0]      synd_s;
    logic              overall_s;
    logic [CW-1:0]     fixCode_s;
    logic              single_s;
    logic              double_s;
    logic              outValid_r;
    logic [DATA_W-1:0] outData_r;
    logic [CW-1:0]     outCode_r;
    logic [P-1:0]      outSyndrome_r;
    logic              outSingle_r;
    logic              outDouble_r;
    logic [CNT_W-1:0]  cntSingle_r;
    logic [CNT_W-1:0]  cntDouble_r;

    assign s2Load_s  = s1Valid_r & (~outValid_r | bus.out_ready);
    assign inFire_s  = bus.in_valid & bus.in_ready;
    assign outFire_s = outValid_r & bus.out_ready;

    assign bus.in_ready     = ~s1Valid_r | ~outValid_r | bus.out_ready;
    assign bus.out_valid    = outValid_r;
    assign bus.out_data     = outData_r;
    assign bus.out_code     = outCode_r;
    assign bus.out_syndrome = outSyndrome_r;
    assign bus.out_single   = outSingle_r;
    assign bus.out_double   = outDouble_r;
    assign bus.cnt_single   = cntSingle_r;
    assign bus.cnt_double   = cntDouble_r;

    // Select the source codeword and apply the injected error pattern.
    always_comb begin
        if (bus.src_sel) begin
            stage1Word_s = bus.in_code ^ bus.err_mask;
        end else begin
            stage1Word_s = encode(bus.in_data) ^ bus.err_mask;
        end
    end

    // Stage 1 holds its word until stage 2 can take it.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1Valid_r <= 1'b0;
            s1Code_r  <= '0;
        end else if (inFire_s) begin
            s1Valid_r <= 1'b1;
            s1Code_r  <= stage1Word_s;
        end else if (s2Load_s) begin
            s1Valid_r <= 1'b0;
        end
    end

    // Classify the stage-1 word; a syndrome beyond the codeword means more than one error.
    always_comb begin
        synd_s    = syndrome(s1Code_r);
        overall_s = ^s1Code_r;
        fixCode_s = s1Code_r;
        single_s  = 1'b0;
        double_s  = 1'b0;
        if (!overall_s) begin
            double_s = (synd_s != '0);
        end else if (int'(synd_s) < CW) begin
            single_s  = 1'b1;
            fixCode_s = s1Code_r ^ (oneCw << synd_s);
        end else begin
            double_s = 1'b1;
        end
    end

    // Output stage; fields only change when a new word is loaded.
    always_ff @(posedge clk) begin
        if (rst) begin
            outValid_r    <= 1'b0;
            outData_r     <= '0;
            outCode_r     <= '0;
            outSyndrome_r <= '0;
            outSingle_r   <= 1'b0;
            outDouble_r   <= 1'b0;
        end else if (s2Load_s) begin
            outValid_r    <= 1'b1;
            outData_r     <= extract(fixCode_s);
            outCode_r     <= fixCode_s;
            outSyndrome_r <= synd_s;
            outSingle_r   <= single_s;
            outDouble_r   <= double_s;
        end else if (bus.out_ready) begin
            outValid_r <= 1'b0;
        end
    end

    // Saturating error counters; clear has priority over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || bus.cnt_clr) begin
            cntSingle_r <= '0;
            cntDouble_r <= '0;
        end else begin
            if (outFire_s && outSingle_r && (cntSingle_r != '1)) begin
                cntSingle_r <= cntSingle_r + CNT_W'(1);
            end
            if (outFire_s && outDouble_r && (cntDouble_r != '1)) begin
                cntDouble_r <= cntDouble_r + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_hamming_secded_pipe.sv
// Scoreboard bench for the SECDED codec: a 4-bit instance under random traffic and
// backpressure, and a 32-bit instance with 2-bit counters for saturation and clear.
module tb_hamming_secded_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hamming_secded_pipe_if #(.DATA_W(4),  .CNT_W(16)) busA ();
    hamming_secded_pipe_if #(.DATA_W(32), .CNT_W(2))  busB ();

    hamming_secded_pipe #(.DATA_W(4),  .CNT_W(16)) dutA (.clk(clk), .rst(rst), .bus(busA));
    hamming_secded_pipe #(.DATA_W(32), .CNT_W(2))  dutB (.clk(clk), .rst(rst), .bus(busB));

    typedef struct {
        logic [3:0] data;
        logic [7:0] code;
        int         syn;
        logic       single;
        logic       dbl;
        int         acc;
    } exp_t;

    exp_t expQ[$];
    int   vectors   = 0;
    int   fails     = 0;
    int   cyc       = 0;
    int   readyMode = 0;
    logic clrRand   = 1'b0;
    int   lastXfer  = -100;
    logic presented = 1'b0;
    logic rstSeen   = 1'b0;
    int   mCntS     = 0;
    int   mCntD     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        vectors++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Reference model: codeword defined position by position, decode by nearest-codeword search.
    function automatic logic [63:0] mEnc(input logic [63:0] d, input int dw, input int cw);
        logic [63:0] c;
        logic [63:0] m;
        int          k;
        c = 64'd0;
        k = 0;
        for (int pos = 1; pos < cw; pos++) begin
            if ($countones(pos) != 1 && k < dw) begin
                c[pos] = d[k];
                k++;
            end
        end
        for (int b = 0; (1 << b) < cw; b++) begin
            m = 64'd0;
            for (int pos = 1; pos < cw; pos++) m[pos] = ((pos & (1 << b)) != 0);
            c[1 << b] = (($countones(c & m) % 2) == 1);
        end
        c[0] = (($countones(c) % 2) == 1);
        return c;
    endfunction

    function automatic logic [63:0] mExtract(input logic [63:0] r, input int cw);
        logic [63:0] d;
        int          k;
        d = 64'd0;
        k = 0;
        for (int pos = 1; pos < cw; pos++) begin
            if ($countones(pos) != 1) begin
                d[k] = r[pos];
                k++;
            end
        end
        return d;
    endfunction

    function automatic int mSyn(input logic [63:0] r, input int cw);
        int s;
        s = 0;
        for (int pos = 1; pos < cw; pos++) if (r[pos]) s = s ^ pos;
        return s;
    endfunction

    task automatic mClassify(input logic [63:0] r, input int dw, input int cw,
                             output logic [63:0] code, output logic single, output logic dbl);
        logic [63:0] f;
        code   = r;
        single = 1'b0;
        dbl    = 1'b0;
        if (mEnc(mExtract(r, cw), dw, cw) != r) begin
            dbl = 1'b1;
            for (int i = 0; i < cw; i++) begin
                f = r ^ (64'd1 << i);
                if (mEnc(mExtract(f, cw), dw, cw) == f) begin
                    code   = f;
                    single = 1'b1;
                    dbl    = 1'b0;
                end
            end
        end
    endtask

    task automatic sendA(input logic [3:0] d, input logic [7:0] code, input logic sel, input logic [7:0] mask);
        int          budget;
        logic        fired;
        exp_t        e;
        logic [63:0] r;
        logic [63:0] fixed;
        logic [63:0] dx;
        busA.in_data  = d;
        busA.in_code  = code;
        busA.src_sel  = sel;
        busA.err_mask = mask;
        busA.in_valid = 1'b1;
        r = sel ? 64'(code) : mEnc(64'(d), 4, 8);
        r = r ^ 64'(mask);
        mClassify(r, 4, 8, fixed, e.single, e.dbl);
        dx     = mExtract(fixed, 8);
        e.data = dx[3:0];
        e.code = fixed[7:0];
        e.syn  = mSyn(r, 8);
        fired  = 1'b0;
        budget = 0;
        while (!fired && budget < 200) begin
            @(negedge clk);
            fired = busA.in_ready && !rst;
            e.acc = cyc;
            @(posedge clk);
            if (fired) expQ.push_back(e);
            #1;
            budget++;
        end
        busA.in_valid = 1'b0;
        if (!fired) begin
            vectors++;
            fails++;
            $display("FAIL send timeout: in_ready stayed low for %0d cycles", budget);
        end
    endtask

    // Downstream side of instance A: ready pattern and occasional counter clears.
    initial begin
        busA.out_ready = 1'b1;
        busA.cnt_clr   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0:       busA.out_ready = 1'b1;
                1:       busA.out_ready = 1'($urandom_range(0, 1));
                default: busA.out_ready = 1'b0;
            endcase
            busA.cnt_clr = clrRand && ($urandom_range(0, 15) == 0);
        end
    end

    // Monitor: compares every output transfer, ready, latency and counters against the model.
    always @(negedge clk) begin : monitor
        exp_t e;
        int   want;
        logic xs;
        logic xd;
        xs = 1'b0;
        xd = 1'b0;
        if (rst) begin
            expQ.delete();
            presented = 1'b0;
            lastXfer  = -100;
            mCntS     = 0;
            mCntD     = 0;
            rstSeen   = 1'b1;
        end else begin
            if (rstSeen) begin
                check("reset out_valid",  64'(busA.out_valid),    64'd0);
                check("reset out_data",   64'(busA.out_data),     64'd0);
                check("reset out_code",   64'(busA.out_code),     64'd0);
                check("reset syndrome",   64'(busA.out_syndrome), 64'd0);
                check("reset flags",      64'({busA.out_single, busA.out_double}), 64'd0);
                check("reset B out_valid", 64'(busB.out_valid),   64'd0);
                rstSeen = 1'b0;
            end
            check("in_ready", 64'(busA.in_ready), 64'((expQ.size() < 2) || busA.out_ready));
            check("cnt_single", 64'(busA.cnt_single), 64'(mCntS));
            check("cnt_double", 64'(busA.cnt_double), 64'(mCntD));
            if (busA.out_valid) begin
                if (expQ.size() == 0) begin
                    vectors++;
                    fails++;
                    $display("FAIL spurious out_valid: got 1, expected 0 (cycle %0d)", cyc);
                end else begin
                    e = expQ[0];
                    if (!presented) begin
                        want = (e.acc + 2 > lastXfer + 1) ? e.acc + 2 : lastXfer + 1;
                        check("latency", 64'(cyc), 64'(want));
                        presented = 1'b1;
                    end
                    if (busA.out_ready) begin
                        check("out_data",     64'(busA.out_data),     64'(e.data));
                        check("out_code",     64'(busA.out_code),     64'(e.code));
                        check("out_syndrome", 64'(busA.out_syndrome), 64'(e.syn));
                        check("out_single",   64'(busA.out_single),   64'(e.single));
                        check("out_double",   64'(busA.out_double),   64'(e.dbl));
                        xs = e.single;
                        xd = e.dbl;
                        void'(expQ.pop_front());
                        presented = 1'b0;
                        lastXfer  = cyc;
                    end
                end
            end
            if (busA.cnt_clr) begin
                mCntS = 0;
                mCntD = 0;
            end else begin
                if (xs && mCntS < 65535) mCntS++;
                if (xd && mCntD < 65535) mCntD++;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [7:0]  m;
        logic [7:0]  code;
        logic [63:0] cb;
        logic [63:0] rb;
        logic [31:0] db;
        int          b1;
        int          b2;
        int          kind;
        busA.in_valid = 1'b0; busA.in_data = 4'd0; busA.in_code = 8'd0;
        busA.src_sel  = 1'b0; busA.err_mask = 8'd0;
        busB.in_valid = 1'b0; busB.in_data = 32'd0; busB.in_code = 39'd0;
        busB.src_sel  = 1'b0; busB.err_mask = 39'd0; busB.out_ready = 1'b1; busB.cnt_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        sendA(4'b1011, 8'h00, 1'b0, 8'h00);
        sendA(4'b1011, 8'h00, 1'b0, 8'h20);
        sendA(4'b1011, 8'h00, 1'b0, 8'h01);
        sendA(4'b1011, 8'h00, 1'b0, 8'h24);
        sendA(4'b0000, 8'hAA, 1'b1, 8'h00);
        repeat (4) @(posedge clk);
        #1;

        readyMode = 2;
        fork
            begin
                for (int i = 0; i < 4; i++) sendA(4'($urandom_range(0, 15)), 8'h00, 1'b0, 8'h00);
            end
            begin
                repeat (4) @(posedge clk);
                readyMode = 0;
            end
        join
        repeat (4) @(posedge clk);
        #1;

        readyMode = 1;
        clrRand   = 1'b1;
        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 3);
            b1   = $urandom_range(0, 7);
            b2   = (b1 + $urandom_range(1, 7)) % 8;
            case (kind)
                0:       m = 8'h00;
                1:       m = 8'd1 << b1;
                2:       m = (8'd1 << b1) | (8'd1 << b2);
                default: m = 8'($urandom_range(0, 255));
            endcase
            cb   = mEnc(64'($urandom_range(0, 15)), 4, 8);
            code = ($urandom_range(0, 1) == 1) ? cb[7:0] : 8'($urandom_range(0, 255));
            sendA(4'($urandom_range(0, 15)), code, 1'($urandom_range(0, 1)), m);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        clrRand   = 1'b0;
        readyMode = 0;
        repeat (6) @(posedge clk);
        #1;

        readyMode = 2;
        @(posedge clk);
        #1;
        sendA(4'b0110, 8'h00, 1'b0, 8'h08);
        sendA(4'b1001, 8'h00, 1'b0, 8'h00);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        readyMode = 0;
        repeat (3) @(posedge clk);
        #1;
        sendA(4'b1011, 8'h00, 1'b0, 8'h40);
        repeat (10) @(posedge clk);
        #1;
        check("queue drained", 64'(expQ.size()), 64'd0);

        for (int i = 0; i < 6; i++) begin
            db = $urandom;
            b1 = $urandom_range(0, 38);
            cb = mEnc(64'(db), 32, 39);
            rb = cb ^ (64'd1 << b1);
            busB.in_data  = db;
            busB.err_mask = 39'(64'd1 << b1);
            busB.in_valid = 1'b1;
            @(negedge clk);
            check("B in_ready", 64'(busB.in_ready), 64'd1);
            @(posedge clk);
            #1 busB.in_valid = 1'b0;
            @(posedge clk);
            #1 busB.cnt_clr = (i == 5);
            @(negedge clk);
            check("B out_valid",    64'(busB.out_valid),    64'd1);
            check("B out_single",   64'(busB.out_single),   64'd1);
            check("B out_double",   64'(busB.out_double),   64'd0);
            check("B out_data",     64'(busB.out_data),     64'(db));
            check("B out_code",     64'(busB.out_code),     cb);
            check("B out_syndrome", 64'(busB.out_syndrome), 64'(mSyn(rb, 39)));
            @(posedge clk);
            #1 busB.cnt_clr = 1'b0;
            @(negedge clk);
            check("B cnt_single", 64'(busB.cnt_single), (i == 5) ? 64'd0 : 64'((i + 1 < 3) ? i + 1 : 3));
            check("B cnt_double", 64'(busB.cnt_double), 64'd0);
            @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
